// File: rtl/spi_adc_responder_if.sv
// Sample-source handshake and SPI pin bundle for spi_adc_responder.
// The master side is the sample source plus SPI controller; the slave side is the responder.
interface spi_adc_responder_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH = 4
);
  logic [DATA_WIDTH-1:0]            sample_in;
  logic                             sample_valid_in;
  logic                             sample_ready_out;
  logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count_out;
  logic                             chip_clk_in;
  logic                             chip_sel_in;
  logic                             chip_data_out;
  logic                             frame_done_out;
  logic                             frame_abort_out;
  logic                             underrun_out;

  modport master (
    output sample_in,
    output sample_valid_in,
    output chip_clk_in,
    output chip_sel_in,
    input  sample_ready_out,
    input  fifo_count_out,
    input  chip_data_out,
    input  frame_done_out,
    input  frame_abort_out,
    input  underrun_out
  );

  modport slave (
    input  sample_in,
    input  sample_valid_in,
    input  chip_clk_in,
    input  chip_sel_in,
    output sample_ready_out,
    output fifo_count_out,
    output chip_data_out,
    output frame_done_out,
    output frame_abort_out,
    output underrun_out
  );
endinterface

// File: rtl/spi_adc_responder.sv
// SPI mode-0 responder standing in for the receive-path ADC.
// Buffers samples in a small FIFO and shifts one word out MSB first per CS frame,
// oversampling SCLK/CS in the clk_in domain.
module spi_adc_responder #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk_in,
  input  logic                 rst_n,
  spi_adc_responder_if.slave   bus
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned BIT_W = $clog2(DATA_WIDTH + 1);

  localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(FIFO_DEPTH);
  localparam logic [BIT_W-1:0] BIT_FULL_C = BIT_W'(DATA_WIDTH);
  localparam logic [BIT_W-1:0] BIT_LAST_C = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Pin synchronisers and edge detection
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic                   sclk_hist_q;
  logic                   cs_hist_q;
  logic                   sclk_rise_q;
  logic                   sclk_fall_q;
  logic                   cs_rise_q;
  logic                   cs_fall_q;

  // Synchronise SCLK/CS and register one-cycle edge flags.
  // CS chain resets low so a frame already in progress at reset release
  // produces no cs_fall; a CS that is high at release shows up as a cs_rise
  // in IDLE, which the FSM ignores.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '0;
      sclk_hist_q <= 1'b0;
      cs_hist_q   <= 1'b0;
      sclk_rise_q <= 1'b0;
      sclk_fall_q <= 1'b0;
      cs_rise_q   <= 1'b0;
      cs_fall_q   <= 1'b0;
    end else begin
      sclk_sync_q[0] <= bus.chip_clk_in;
      cs_sync_q[0]   <= bus.chip_sel_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sclk_sync_q[i] <= sclk_sync_q[i-1];
        cs_sync_q[i]   <= cs_sync_q[i-1];
      end
      sclk_hist_q <= sclk_sync_q[SYNC_STAGES-1];
      cs_hist_q   <= cs_sync_q[SYNC_STAGES-1];
      sclk_rise_q <=  sclk_sync_q[SYNC_STAGES-1] & ~sclk_hist_q;
      sclk_fall_q <= ~sclk_sync_q[SYNC_STAGES-1] &  sclk_hist_q;
      cs_rise_q   <=  cs_sync_q[SYNC_STAGES-1]   & ~cs_hist_q;
      cs_fall_q   <= ~cs_sync_q[SYNC_STAGES-1]   &  cs_hist_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Sample FIFO
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [CNT_W-1:0]      count_q;
  logic [CNT_W-1:0]      count_d;
  logic                  ready_q;
  logic                  fifo_empty;
  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] rd_data;
  state_t                state_q;

  assign fifo_empty = (count_q == '0);
  assign push       = bus.sample_valid_in & ready_q;
  // Pop decision uses the pre-push count, so a push landing with cs_fall
  // on an empty FIFO stays queued and the frame underruns.
  assign pop        = cs_fall_q & (state_q == IDLE) & ~fifo_empty;
  assign rd_data    = mem_q[rd_ptr_q];

  // Next occupancy from the push/pop combination.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage array; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk_in) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.sample_in;
    end
  end

  // Pointers, occupancy and registered ready.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b1;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_d;
      ready_q <= (count_d < DEPTH_C);
    end
  end

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] shift_q;
  logic [DATA_WIDTH-1:0] last_sample_q;
  logic [BIT_W-1:0]      bit_cnt_q;
  logic                  data_q;
  logic                  done_q;
  logic                  abort_q;
  logic                  underrun_q;

  // Frame sequencing, shift register and registered CIPO / status pulses.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      shift_q       <= '0;
      last_sample_q <= '0;
      bit_cnt_q     <= '0;
      data_q        <= 1'b0;
      done_q        <= 1'b0;
      abort_q       <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      abort_q    <= 1'b0;
      underrun_q <= 1'b0;
      // cs_rise in IDLE only happens right after reset release; no frame was
      // started, so it is not reported as done or aborted.
      if (cs_rise_q && (state_q != IDLE)) begin
        state_q <= IDLE;
        data_q  <= 1'b0;
        if (bit_cnt_q == BIT_FULL_C) begin
          done_q <= 1'b1;
        end else begin
          abort_q <= 1'b1;
        end
      end else begin
        case (state_q)
          IDLE: begin
            data_q <= 1'b0;
            if (cs_fall_q) begin
              if (fifo_empty) begin
                shift_q    <= last_sample_q;
                data_q     <= last_sample_q[DATA_WIDTH-1];
                underrun_q <= 1'b1;
              end else begin
                shift_q       <= rd_data;
                last_sample_q <= rd_data;
                data_q        <= rd_data[DATA_WIDTH-1];
              end
              bit_cnt_q <= '0;
              state_q   <= SHIFT;
            end
          end
          SHIFT: begin
            if (sclk_rise_q) begin
              bit_cnt_q <= bit_cnt_q + BIT_W'(1);
              if (bit_cnt_q == BIT_LAST_C) begin
                state_q <= DRAIN;
                data_q  <= 1'b0;
              end
            end else if (sclk_fall_q) begin
              shift_q <= shift_q << 1;
              data_q  <= shift_q[DATA_WIDTH-2];
            end
          end
          DRAIN: begin
            data_q <= 1'b0;
          end
          default: begin
            state_q <= IDLE;
            data_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.chip_data_out    = data_q;
  assign bus.frame_done_out   = done_q;
  assign bus.frame_abort_out  = abort_q;
  assign bus.underrun_out     = underrun_q;
  assign bus.sample_ready_out = ready_q;
  assign bus.fifo_count_out   = count_q;

endmodule
